// File: rtl/tis_pkg.sv
// Shared definitions for the node fetch and decode stages: default widths,
// next-PC operation codes, the NOP opcode and the fetch state encoding.
package tis_pkg;

    localparam int DEF_OP_W   = 21;
    localparam int DEF_DATA_W = 11;
    localparam int DEF_ADDR_W = 4;

    localparam logic [3:0] PC_NEXT = 4'd0;
    localparam logic [3:0] PC_JMP  = 4'd1;
    localparam logic [3:0] PC_JEZ  = 4'd2;
    localparam logic [3:0] PC_JNZ  = 4'd3;
    localparam logic [3:0] PC_JGZ  = 4'd4;
    localparam logic [3:0] PC_JLZ  = 4'd5;
    localparam logic [3:0] PC_JRO  = 4'd6;

    localparam logic [DEF_OP_W-1:0] OP_NOP = '0;

    typedef enum logic [1:0] {
        FETCH_EMPTY = 2'd0,
        FETCH_LOAD  = 2'd1,
        FETCH_RUN   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/prog_mem.sv
// Node program store: one synchronous write port, asynchronous read port.
// Contents are never reset; the host reloads after every reset.
module prog_mem #(
    parameter int OP_W   = 21,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OP_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OP_W-1:0]   rdata
);

    logic [OP_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Per-node program counter and program store front end: host load path,
// EMPTY/LOAD/RUN control and next-PC selection fed back from op_decode.
module instr_fetch
    import tis_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_en,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [OP_W-1:0]          prog_data,
    input  logic                     step,
    input  logic [3:0]               pc_instr,
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] jro_offset,
    output logic [OP_W-1:0]          op_code,
    output logic                     op_valid,
    output logic [ADDR_W-1:0]        pc
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] last, last_nxt;
    logic              wrote, wrote_nxt;
    logic              first_write;
    logic [OP_W-1:0]   rd_data;
    logic [ADDR_W-1:0] seq_pc, tgt, tgt_pc, branch_pc;
    logic              acc_zero, acc_neg;

    // Relative jump: pc zero-extended, offset sign-extended, one guard bit,
    // then clamped into the loaded program range [0, lim].
    function automatic logic [ADDR_W-1:0] jro_clamp(
        input logic [ADDR_W-1:0]        base,
        input logic signed [DATA_W-1:0] off,
        input logic [ADDR_W-1:0]        lim
    );
        logic signed [DATA_W:0] sum;
        logic signed [DATA_W:0] lim_s;
        sum   = $signed({{(DATA_W+1-ADDR_W){1'b0}}, base}) + $signed({off[DATA_W-1], off});
        lim_s = $signed({{(DATA_W+1-ADDR_W){1'b0}}, lim});
        if (sum[DATA_W]) begin
            return '0;
        end else if (sum > lim_s) begin
            return lim;
        end else begin
            return sum[ADDR_W-1:0];
        end
    endfunction

    prog_mem #(
        .OP_W   (OP_W),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (load_en && prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (rd_data)
    );

    assign op_valid = (state == FETCH_RUN);
    assign op_code  = op_valid ? rd_data : OP_W'(OP_NOP);

    assign acc_zero = (acc == '0);
    assign acc_neg  = acc[DATA_W-1];

    // Branch targets use the raw label field of the instruction at pc.
    always_comb begin
        seq_pc    = (pc == last) ? '0 : pc + 1'b1;
        tgt       = rd_data[ADDR_W-1:0];
        tgt_pc    = (tgt > last) ? '0 : tgt;
        branch_pc = seq_pc;
        case (pc_instr)
            PC_JMP:  branch_pc = tgt_pc;
            PC_JEZ:  branch_pc = acc_zero ? tgt_pc : seq_pc;
            PC_JNZ:  branch_pc = !acc_zero ? tgt_pc : seq_pc;
            PC_JGZ:  branch_pc = (!acc_zero && !acc_neg) ? tgt_pc : seq_pc;
            PC_JLZ:  branch_pc = acc_neg ? tgt_pc : seq_pc;
            PC_JRO:  branch_pc = jro_clamp(pc, jro_offset, last);
            default: branch_pc = seq_pc;
        endcase
    end

    // load_en takes priority over step; a LOAD with no writes falls back to EMPTY.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        last_nxt    = last;
        wrote_nxt   = 1'b0;
        first_write = (state != FETCH_LOAD) || !wrote;
        if (load_en) begin
            state_nxt = FETCH_LOAD;
            pc_nxt    = '0;
            wrote_nxt = (state == FETCH_LOAD) && wrote;
            if (prog_we) begin
                wrote_nxt = 1'b1;
                if (first_write || (prog_addr > last)) begin
                    last_nxt = prog_addr;
                end
            end
        end else begin
            case (state)
                FETCH_LOAD: state_nxt = wrote ? FETCH_RUN : FETCH_EMPTY;
                FETCH_RUN: begin
                    if (step) begin
                        pc_nxt = branch_pc;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH_EMPTY;
            pc    <= '0;
            last  <= '0;
            wrote <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            last  <= last_nxt;
            wrote <= wrote_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: hand sequences for load/run/stall/reset corners plus
// a table of next-PC vectors, checked through an expectation queue.
module tb_instr_fetch;
    import tis_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               load_en;
    logic               prog_we;
    logic [3:0]         prog_addr;
    logic [20:0]        prog_data;
    logic               step;
    logic [3:0]         pc_instr;
    logic signed [10:0] acc;
    logic signed [10:0] jro_offset;
    logic [20:0]        op_code;
    logic               op_valid;
    logic [3:0]         pc;

    int n_assert = 0;
    int n_fail   = 0;

    logic [20:0] prog_std [4];
    logic [20:0] exp_mem  [16];

    typedef struct {
        string       name;
        logic [3:0]  pc;
        logic        valid;
        logic [20:0] op;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string              name;
        logic [3:0]         start_pc;
        logic [3:0]         code;
        logic signed [10:0] acc;
        logic signed [10:0] jro;
        logic               step;
        logic [3:0]         exp_pc;
    } vec_t;
    vec_t vec [20];

    instr_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .step       (step),
        .pc_instr   (pc_instr),
        .acc        (acc),
        .jro_offset (jro_offset),
        .op_code    (op_code),
        .op_valid   (op_valid),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] e_pc, input logic e_valid,
                         input logic [20:0] e_op);
        n_assert++;
        if (pc !== e_pc) begin
            n_fail++;
            $display("FAIL %s: pc=%0d expected %0d", name, pc, e_pc);
        end
        n_assert++;
        if (op_valid !== e_valid) begin
            n_fail++;
            $display("FAIL %s: op_valid=%0b expected %0b", name, op_valid, e_valid);
        end
        n_assert++;
        if (op_code !== e_op) begin
            n_fail++;
            $display("FAIL %s: op_code=%h expected %h", name, op_code, e_op);
        end
    endtask

    task automatic expect_run(input string name, input logic [3:0] e_pc);
        sb.push_back('{name, e_pc, 1'b1, exp_mem[e_pc]});
    endtask

    task automatic expect_idle(input string name);
        sb.push_back('{name, 4'd0, 1'b0, 21'd0});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, e.pc, e.valid, e.op);
        end
    endtask

    task automatic idle_inputs();
        load_en    = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 4'd0;
        prog_data  = 21'd0;
        step       = 1'b0;
        pc_instr   = PC_NEXT;
        acc        = 11'sd0;
        jro_offset = 11'sd0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [20:0] d);
        load_en   = 1'b1;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step      = 1'b0;
        exp_mem[a] = d;
        expect_idle("load");
        tick();
    endtask

    task automatic start_run();
        idle_inputs();
        expect_run("run_start", 4'd0);
        tick();
    endtask

    task automatic load_std();
        for (int a = 0; a < 4; a++) write_word(4'(a), prog_std[a]);
        start_run();
    endtask

    task automatic step_op(input string name, input logic [3:0] code, input logic signed [10:0] a,
                           input logic signed [10:0] j, input logic [3:0] e_pc);
        idle_inputs();
        step       = 1'b1;
        pc_instr   = code;
        acc        = a;
        jro_offset = j;
        expect_run(name, e_pc);
        tick();
    endtask

    initial begin
        prog_std[0] = 21'h10001;
        prog_std[1] = 21'h20009;
        prog_std[2] = 21'h30001;
        prog_std[3] = 21'h40002;
        for (int a = 0; a < 16; a++) exp_mem[a] = 21'd0;

        vec[0]  = '{"jlz_neg",      4'd2, PC_JLZ,  -11'sd5,    11'sd0,    1'b1, 4'd1};
        vec[1]  = '{"jgz_neg",      4'd2, PC_JGZ,  -11'sd5,    11'sd0,    1'b1, 4'd3};
        vec[2]  = '{"jez_zero",     4'd2, PC_JEZ,  11'sd0,     11'sd0,    1'b1, 4'd1};
        vec[3]  = '{"jnz_zero",     4'd2, PC_JNZ,  11'sd0,     11'sd0,    1'b1, 4'd3};
        vec[4]  = '{"jnz_pos",      4'd2, PC_JNZ,  11'sd7,     11'sd0,    1'b1, 4'd1};
        vec[5]  = '{"jgz_pos",      4'd2, PC_JGZ,  11'sd7,     11'sd0,    1'b1, 4'd1};
        vec[6]  = '{"jro_m7",       4'd1, PC_JRO,  11'sd0,     -11'sd7,   1'b1, 4'd0};
        vec[7]  = '{"jro_p10",      4'd1, PC_JRO,  11'sd0,     11'sd10,   1'b1, 4'd3};
        vec[8]  = '{"jro_zero",     4'd1, PC_JRO,  11'sd0,     11'sd0,    1'b1, 4'd1};
        vec[9]  = '{"jmp_tgt9",     4'd1, PC_JMP,  11'sd0,     11'sd0,    1'b1, 4'd0};
        vec[10] = '{"next_wrap",    4'd3, PC_NEXT, 11'sd0,     11'sd0,    1'b1, 4'd0};
        vec[11] = '{"jmp_tgt1",     4'd0, PC_JMP,  11'sd0,     11'sd0,    1'b1, 4'd1};
        vec[12] = '{"unknown_code", 4'd2, 4'd15,   11'sd3,     11'sd0,    1'b1, 4'd3};
        vec[13] = '{"jro_m1",       4'd3, PC_JRO,  11'sd0,     -11'sd1,   1'b1, 4'd2};
        vec[14] = '{"jro_min",      4'd0, PC_JRO,  11'sd0,     -11'sd1024, 1'b1, 4'd0};
        vec[15] = '{"jro_max",      4'd3, PC_JRO,  11'sd0,     11'sd1023, 1'b1, 4'd3};
        vec[16] = '{"stall_jmp",    4'd2, PC_JMP,  11'sd0,     11'sd0,    1'b0, 4'd2};
        vec[17] = '{"jez_pc3",      4'd3, PC_JEZ,  11'sd0,     11'sd0,    1'b1, 4'd2};
        vec[18] = '{"jlz_min_acc",  4'd1, PC_JLZ,  -11'sd1024, 11'sd0,    1'b1, 4'd0};
        vec[19] = '{"jlz_zero",     4'd2, PC_JLZ,  11'sd0,     11'sd0,    1'b1, 4'd3};

        // Reset with no program: stays empty while stepping.
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("reset", 4'd0, 1'b0, 21'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step = 1'b1;
            pc_instr = PC_JMP;
            expect_idle("empty_step");
            tick();
        end

        // Load 0..3 and walk sequentially with wrap.
        load_std();
        step_op("seq_1", PC_NEXT, 11'sd0, 11'sd0, 4'd1);
        step_op("seq_2", PC_NEXT, 11'sd0, 11'sd0, 4'd2);
        step_op("seq_3", PC_NEXT, 11'sd0, 11'sd0, 4'd3);
        step_op("seq_0", PC_NEXT, 11'sd0, 11'sd0, 4'd0);
        step_op("seq_1b", PC_NEXT, 11'sd0, 11'sd0, 4'd1);
        step_op("seq_2b", PC_NEXT, 11'sd0, 11'sd0, 4'd2);

        // Stall at pc=2, with a branch request present.
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            pc_instr = PC_JMP;
            expect_run("stall", 4'd2);
            tick();
        end

        // Write strobe outside load mode must not alter the program.
        idle_inputs();
        prog_we   = 1'b1;
        prog_addr = 4'd2;
        prog_data = 21'h1ABCD;
        expect_run("we_ignored", 4'd2);
        tick();
        idle_inputs();
        expect_run("we_ignored2", 4'd2);
        tick();

        // load_en with step on the same cycle, then a write-free LOAD -> EMPTY.
        idle_inputs();
        load_en  = 1'b1;
        step     = 1'b1;
        pc_instr = PC_NEXT;
        expect_idle("load_beats_step");
        tick();
        idle_inputs();
        expect_idle("empty_after_load");
        tick();
        for (int i = 0; i < 2; i++) begin
            step = 1'b1;
            expect_idle("empty_stays");
            tick();
        end

        // First write discards the old last; max of later writes wins.
        write_word(4'd2, prog_std[2]);
        write_word(4'd1, prog_std[1]);
        start_run();
        step_op("last2_1", PC_NEXT, 11'sd0, 11'sd0, 4'd1);
        step_op("last2_2", PC_NEXT, 11'sd0, 11'sd0, 4'd2);
        step_op("last2_wrap", PC_NEXT, 11'sd0, 11'sd0, 4'd0);

        // Single-instruction program: every option resolves to 0.
        write_word(4'd0, 21'h00005);
        start_run();
        step_op("one_jmp", PC_JMP, 11'sd0, 11'sd0, 4'd0);
        step_op("one_next", PC_NEXT, 11'sd0, 11'sd0, 4'd0);
        step_op("one_jro", PC_JRO, 11'sd0, 11'sd5, 4'd0);
        step_op("one_jez", PC_JEZ, 11'sd0, 11'sd0, 4'd0);

        // Next-PC table against the standard program (last=3).
        for (int i = 0; i < 20; i++) begin
            load_std();
            for (int k = 0; k < int'(vec[i].start_pc); k++) begin
                step_op("nav", PC_NEXT, 11'sd0, 11'sd0, 4'(k + 1));
            end
            idle_inputs();
            step       = vec[i].step;
            pc_instr   = vec[i].code;
            acc        = vec[i].acc;
            jro_offset = vec[i].jro;
            expect_run(vec[i].name, vec[i].exp_pc);
            tick();
        end

        // Asynchronous reset mid-RUN at pc=2.
        load_std();
        step_op("pre_rst_1", PC_NEXT, 11'sd0, 11'sd0, 4'd1);
        step_op("pre_rst_2", PC_NEXT, 11'sd0, 11'sd0, 4'd2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b0, 21'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            step = 1'b1;
            expect_idle("post_reset");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
